// File: rtl/axi4_burst_mem_slave_if.sv
// AXI4 write/read channel bundle (AW/W/B/AR/R with IDs) for the burst memory slave.
// The master modport drives requests; the slave modport drives readies and responses.
interface axi4_burst_mem_slave_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4
);
  logic [ID_WIDTH-1:0]     AWID;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic [7:0]              AWLEN;
  logic [2:0]              AWSIZE;
  logic [1:0]              AWBURST;
  logic                    AWVALID;
  logic                    AWREADY;

  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    WLAST;
  logic                    WVALID;
  logic                    WREADY;

  logic [ID_WIDTH-1:0]     BID;
  logic [1:0]              BRESP;
  logic                    BVALID;
  logic                    BREADY;

  logic [ID_WIDTH-1:0]     ARID;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic [7:0]              ARLEN;
  logic [2:0]              ARSIZE;
  logic [1:0]              ARBURST;
  logic                    ARVALID;
  logic                    ARREADY;

  logic [ID_WIDTH-1:0]     RID;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    RLAST;
  logic                    RVALID;
  logic                    RREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY,
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY,
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY
  );
endinterface

// File: rtl/axi4_burst_mem_slave.sv
// AXI4 scratch-RAM slave: FIXED/INCR/WRAP bursts, narrow transfers, byte strobes,
// SLVERR on range/protocol violations; independent read and write engines.
module axi4_burst_mem_slave #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ID_WIDTH   = 4,
  parameter int unsigned MEM_BYTES  = 4096
) (
  input  logic                 ACLK,
  input  logic                 ARESETN,
  axi4_burst_mem_slave_if.slave s
);

  localparam int unsigned NB    = DATA_WIDTH / 8;
  localparam int unsigned BL    = $clog2(NB);
  localparam int unsigned ML    = $clog2(MEM_BYTES);
  localparam int unsigned WORDS = MEM_BYTES / NB;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef logic [ADDR_WIDTH-1:0] addr_t;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_e;

  // Address of beat k computed directly from the burst start, so no running
  // address register is needed on either path.
  function automatic addr_t beat_addr(input addr_t a, input logic [7:0] k,
                                      input logic [2:0] size, input logic [1:0] burst,
                                      input logic [7:0] len);
    addr_t off, lane_mask, cont_mask;
    off       = addr_t'(k) << size;
    lane_mask = (addr_t'(1) << size) - addr_t'(1);
    cont_mask = ((addr_t'(len) + addr_t'(1)) << size) - addr_t'(1);
    case (burst)
      2'b00:   beat_addr = a;
      2'b10:   beat_addr = (a & ~cont_mask) + ((a + off) & cont_mask);
      default: beat_addr = (k == 8'd0) ? a : (a & ~lane_mask) + off;
    endcase
  endfunction

  function automatic logic proto_bad(input logic [2:0] size, input logic [1:0] burst,
                                     input logic [7:0] len);
    proto_bad = (size > 3'(BL)) || (burst == 2'b11) ||
                ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  function automatic logic out_of_range(input addr_t a);
    out_of_range = (a >= addr_t'(MEM_BYTES));
  endfunction

  function automatic logic [ML-BL-1:0] widx(input addr_t a);
    widx = a[ML-1:BL];
  endfunction

  logic [DATA_WIDTH-1:0] mem [WORDS];

  // ---------------- write path ----------------
  w_state_e            w_state_q;
  logic                awready_q, wready_q, bvalid_q;
  logic [1:0]          bresp_q;
  logic [ID_WIDTH-1:0] bid_q;
  addr_t               waddr_q;
  logic [7:0]          wlen_q, wbeat_q;
  logic [2:0]          wsize_q;
  logic [1:0]          wburst_q;
  logic                wperr_q, werr_q;

  addr_t wcur_addr;
  logic  w_hs, w_beat_last, w_beat_err, mem_we;

  assign wcur_addr   = beat_addr(waddr_q, wbeat_q, wsize_q, wburst_q, wlen_q);
  assign w_hs        = wready_q & s.WVALID;
  assign w_beat_last = (wbeat_q == wlen_q);
  assign w_beat_err  = wperr_q | out_of_range(wcur_addr) | (s.WLAST != w_beat_last);
  assign mem_we      = w_hs & ~w_beat_err;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_state_q <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      bid_q     <= '0;
      waddr_q   <= '0;
      wlen_q    <= '0;
      wbeat_q   <= '0;
      wsize_q   <= '0;
      wburst_q  <= '0;
      wperr_q   <= 1'b0;
      werr_q    <= 1'b0;
    end else begin
      case (w_state_q)
        W_IDLE: begin
          awready_q <= 1'b1;
          if (awready_q && s.AWVALID) begin
            awready_q <= 1'b0;
            wready_q  <= 1'b1;
            bid_q     <= s.AWID;
            waddr_q   <= s.AWADDR;
            wlen_q    <= s.AWLEN;
            wsize_q   <= s.AWSIZE;
            wburst_q  <= s.AWBURST;
            wbeat_q   <= '0;
            wperr_q   <= proto_bad(s.AWSIZE, s.AWBURST, s.AWLEN);
            werr_q    <= 1'b0;
            w_state_q <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            wbeat_q <= wbeat_q + 8'd1;
            werr_q  <= werr_q | w_beat_err;
            if (w_beat_last) begin
              wready_q  <= 1'b0;
              bvalid_q  <= 1'b1;
              bresp_q   <= (werr_q | w_beat_err) ? RESP_SLVERR : RESP_OKAY;
              w_state_q <= W_RESP;
            end
          end
        end
        W_RESP: begin
          if (s.BREADY) begin
            bvalid_q  <= 1'b0;
            w_state_q <= W_IDLE;
          end
        end
        default: w_state_q <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK) begin
    if (mem_we) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (s.WSTRB[b]) mem[widx(wcur_addr)][8*b +: 8] <= s.WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read path ----------------
  r_state_e              r_state_q;
  logic                  arready_q, rvalid_q, rlast_q;
  logic [1:0]            rresp_q;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [ID_WIDTH-1:0]   rid_q;
  addr_t                 raddr_q;
  logic [7:0]            rlen_q, rbeat_q;
  logic [2:0]            rsize_q;
  logic [1:0]            rburst_q;
  logic                  rperr_q;

  addr_t rnext_addr;
  logic  ar_perr, ar_bad, rn_bad;

  assign rnext_addr = beat_addr(raddr_q, rbeat_q + 8'd1, rsize_q, rburst_q, rlen_q);
  assign ar_perr    = proto_bad(s.ARSIZE, s.ARBURST, s.ARLEN);
  assign ar_bad     = ar_perr | out_of_range(s.ARADDR);
  assign rn_bad     = rperr_q | out_of_range(rnext_addr);

  // RAM is read at the edge that issues each beat, so a same-cycle write to
  // that word is not yet visible and the pre-write value is returned.
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
      rid_q     <= '0;
      raddr_q   <= '0;
      rlen_q    <= '0;
      rbeat_q   <= '0;
      rsize_q   <= '0;
      rburst_q  <= '0;
      rperr_q   <= 1'b0;
    end else begin
      case (r_state_q)
        R_IDLE: begin
          arready_q <= 1'b1;
          if (arready_q && s.ARVALID) begin
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rid_q     <= s.ARID;
            raddr_q   <= s.ARADDR;
            rlen_q    <= s.ARLEN;
            rsize_q   <= s.ARSIZE;
            rburst_q  <= s.ARBURST;
            rbeat_q   <= '0;
            rperr_q   <= ar_perr;
            rlast_q   <= (s.ARLEN == 8'd0);
            rresp_q   <= ar_bad ? RESP_SLVERR : RESP_OKAY;
            rdata_q   <= ar_bad ? '0 : mem[widx(s.ARADDR)];
            r_state_q <= R_DATA;
          end
        end
        R_DATA: begin
          if (s.RREADY) begin
            if (rlast_q) begin
              rvalid_q  <= 1'b0;
              rlast_q   <= 1'b0;
              r_state_q <= R_IDLE;
            end else begin
              rbeat_q <= rbeat_q + 8'd1;
              rlast_q <= ((rbeat_q + 8'd1) == rlen_q);
              rresp_q <= rn_bad ? RESP_SLVERR : RESP_OKAY;
              rdata_q <= rn_bad ? '0 : mem[widx(rnext_addr)];
            end
          end
        end
        default: r_state_q <= R_IDLE;
      endcase
    end
  end

  assign s.AWREADY = awready_q;
  assign s.WREADY  = wready_q;
  assign s.BVALID  = bvalid_q;
  assign s.BRESP   = bresp_q;
  assign s.BID     = bid_q;
  assign s.ARREADY = arready_q;
  assign s.RVALID  = rvalid_q;
  assign s.RDATA   = rdata_q;
  assign s.RRESP   = rresp_q;
  assign s.RLAST   = rlast_q;
  assign s.RID     = rid_q;

endmodule

// File: tb/tb_axi4_burst_mem_slave.sv
// Randomized bench for axi4_burst_mem_slave: byte-array memory model plus
// expected-response queues checked every cycle the response channels are valid.
module tb_axi4_burst_mem_slave;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam int MB = 4096;
  localparam int NB = DW / 8;

  logic ACLK = 1'b0;
  logic ARESETN = 1'b0;
  always #5 ACLK = ~ACLK;

  axi4_burst_mem_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW)) bus ();

  axi4_burst_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .ID_WIDTH(IW), .MEM_BYTES(MB)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .s(bus)
  );

  typedef struct {logic [IW-1:0] id; logic [DW-1:0] data; logic [1:0] resp; logic last;} rexp_t;
  typedef struct {logic [IW-1:0] id; logic [1:0] resp;} bexp_t;

  rexp_t exp_r[$];
  bexp_t exp_b[$];
  logic [7:0] mm [MB];

  logic [DW-1:0] got_d[$];
  logic          got_l[$];
  logic [1:0]    got_rr[$];
  int            got_n = 0;
  logic [IW-1:0] got_bid;
  logic [1:0]    got_bresp;
  int            b_wait = 0, b_wait_last = 0, r_stall = 0;
  int            rhold = 0, bhold = 0;
  int            total = 0, bad = 0;

  logic [DW-1:0] wd [16];
  logic [NB-1:0] ws [16];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic tmo(input string nm, input bit ok);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s got=timeout exp=handshake t=%0t", nm, $time);
    end
  endtask

  // Reference address rule, written with plain integer arithmetic.
  function automatic int maddr(int a, int k, int size, int burst, int len);
    int nb, cont;
    nb = 1 << size;
    if (burst == 0) return a;
    if (burst == 2) begin
      cont = nb * (len + 1);
      return (a / cont) * cont + ((a + k * nb) % cont);
    end
    return (k == 0) ? a : (a / nb) * nb + k * nb;
  endfunction

  function automatic bit mperr(int size, int burst, int len);
    return (size > $clog2(NB)) || (burst == 3) ||
           (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15));
  endfunction

  function automatic logic [DW-1:0] mword(int a);
    logic [DW-1:0] r;
    int w;
    w = (a / NB) * NB;
    for (int b = 0; b < NB; b++) r[8*b +: 8] = mm[w + b];
    return r;
  endfunction

  // Ready drivers: hold low for a number of valid cycles on request, else random.
  always @(posedge ACLK) begin
    #1;
    if (rhold > 0) begin bus.RREADY = 1'b0; if (bus.RVALID) rhold--; end
    else bus.RREADY = ($urandom_range(0, 3) != 0);
    if (bhold > 0) begin bus.BREADY = 1'b0; if (bus.BVALID) bhold--; end
    else bus.BREADY = ($urandom_range(0, 3) != 0);
  end

  // Single compare process: response channels against the model queues.
  always @(negedge ACLK) begin
    if (ARESETN) begin
      if (bus.RVALID) begin
        if (exp_r.size() == 0) chk("r_unexpected", 1'b1, 1'b0);
        else begin
          chk("rid", bus.RID, exp_r[0].id);
          chk("rdata", bus.RDATA, exp_r[0].data);
          chk("rresp", bus.RRESP, exp_r[0].resp);
          chk("rlast", bus.RLAST, exp_r[0].last);
          if (!bus.RREADY) r_stall++;
          else begin
            got_d.push_back(bus.RDATA);
            got_l.push_back(bus.RLAST);
            got_rr.push_back(bus.RRESP);
            got_n++;
            void'(exp_r.pop_front());
          end
        end
      end
      if (bus.BVALID) begin
        if (exp_b.size() == 0) chk("b_unexpected", 1'b1, 1'b0);
        else begin
          chk("bid", bus.BID, exp_b[0].id);
          chk("bresp", bus.BRESP, exp_b[0].resp);
          b_wait++;
          if (bus.BREADY) begin
            got_bid = bus.BID;
            got_bresp = bus.BRESP;
            b_wait_last = b_wait;
            b_wait = 0;
            void'(exp_b.pop_front());
          end
        end
      end
    end
  end

  task automatic do_write(input int id, input int a, input int len, input int size,
                          input int burst, input int badlast);
    bit perr, err, lb, inr, lok;
    int ba, w, t;
    perr = mperr(size, burst, len);
    err = perr;
    for (int k = 0; k <= len; k++) begin
      ba = maddr(a, k, size, burst, len);
      lb = (badlast >= 0) ? (k == badlast) : (k == len);
      inr = (ba < MB);
      lok = (lb == (k == len));
      if (!perr && inr && lok) begin
        w = (ba / NB) * NB;
        for (int b = 0; b < NB; b++) if (ws[k][b]) mm[w + b] = wd[k][8*b +: 8];
      end
      if (!inr || !lok) err = 1'b1;
    end
    exp_b.push_back('{id: IW'(id), resp: err ? 2'b10 : 2'b00});
    bus.AWID = IW'(id); bus.AWADDR = AW'(a); bus.AWLEN = 8'(len);
    bus.AWSIZE = 3'(size); bus.AWBURST = 2'(burst); bus.AWVALID = 1'b1;
    t = 0;
    @(negedge ACLK);
    while (!bus.AWREADY && t < 200) begin @(negedge ACLK); t++; end
    tmo("aw_wait", t < 200);
    @(posedge ACLK); #1;
    bus.AWVALID = 1'b0;
    for (int k = 0; k <= len; k++) begin
      if ($urandom_range(0, 3) == 0) begin bus.WVALID = 1'b0; @(posedge ACLK); #1; end
      bus.WDATA = wd[k]; bus.WSTRB = ws[k];
      bus.WLAST = (badlast >= 0) ? (k == badlast) : (k == len);
      bus.WVALID = 1'b1;
      t = 0;
      @(negedge ACLK);
      while (!bus.WREADY && t < 200) begin @(negedge ACLK); t++; end
      tmo("w_wait", t < 200);
      @(posedge ACLK); #1;
    end
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    t = 0;
    while (exp_b.size() != 0 && t < 300) begin @(posedge ACLK); t++; end
    tmo("b_wait", t < 300);
    #1;
  endtask

  task automatic r_expect(input int id, input int a, input int len, input int size, input int burst);
    bit perr, e;
    int ba;
    perr = mperr(size, burst, len);
    for (int k = 0; k <= len; k++) begin
      ba = maddr(a, k, size, burst, len);
      e = perr || (ba >= MB);
      exp_r.push_back('{id: IW'(id), data: e ? '0 : mword(ba), resp: e ? 2'b10 : 2'b00, last: (k == len)});
    end
  endtask

  task automatic issue_ar(input int id, input int a, input int len, input int size, input int burst);
    int t;
    bus.ARID = IW'(id); bus.ARADDR = AW'(a); bus.ARLEN = 8'(len);
    bus.ARSIZE = 3'(size); bus.ARBURST = 2'(burst); bus.ARVALID = 1'b1;
    t = 0;
    @(negedge ACLK);
    while (!bus.ARREADY && t < 200) begin @(negedge ACLK); t++; end
    tmo("ar_wait", t < 200);
    @(posedge ACLK); #1;
    bus.ARVALID = 1'b0;
  endtask

  task automatic do_read(input int id, input int a, input int len, input int size, input int burst);
    int t;
    r_expect(id, a, len, size, burst);
    issue_ar(id, a, len, size, burst);
    t = 0;
    while (exp_r.size() != 0 && t < 600) begin @(posedge ACLK); t++; end
    tmo("r_done", t < 600);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, t, id, a, len, size, burst, badlast;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = '0; bus.AWBURST = '0; bus.AWVALID = 1'b0;
    bus.WDATA = '0; bus.WSTRB = '0; bus.WLAST = 1'b0; bus.WVALID = 1'b0; bus.BREADY = 1'b0;
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = '0; bus.ARBURST = '0; bus.ARVALID = 1'b0;
    bus.RREADY = 1'b0;

    repeat (3) @(negedge ACLK);
    chk("rst_awready", bus.AWREADY, 1'b0);
    chk("rst_wready", bus.WREADY, 1'b0);
    chk("rst_bvalid", bus.BVALID, 1'b0);
    chk("rst_arready", bus.ARREADY, 1'b0);
    chk("rst_rvalid", bus.RVALID, 1'b0);
    chk("rst_rdata", bus.RDATA, 32'h0);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("rel_awready", bus.AWREADY, 1'b1);
    chk("rel_arready", bus.ARREADY, 1'b1);
    @(posedge ACLK); #1;

    chk("pin_wrap_addr", 128'(maddr('h38, 2, 2, 2, 3)), 128'h30);
    chk("pin_incr_addr", 128'(maddr('h13, 1, 2, 1, 3)), 128'h14);

    // Give the whole RAM defined contents.
    for (int i = 0; i < MB / (16 * NB); i++) begin
      for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = '1; end
      do_write(i % 16, i * 16 * NB, 15, 2, 1, -1);
    end

    // INCR write then read-back.
    for (int k = 0; k < 4; k++) begin wd[k] = DW'(k + 1); ws[k] = 4'hF; end
    do_write(3, 'h10, 3, 2, 1, -1);
    chk("incr_bid", got_bid, 4'd3);
    chk("incr_bresp", got_bresp, 2'b00);
    base = got_n;
    do_read(3, 'h10, 3, 2, 1);
    for (int k = 0; k < 4; k++) chk("incr_rdata", got_d[base + k], 128'(k + 1));
    chk("incr_rlast3", got_l[base + 3], 1'b1);
    chk("incr_rlast2", got_l[base + 2], 1'b0);

    // WRAP: beats land at 0x38,0x3C,0x30,0x34.
    for (int k = 0; k < 4; k++) begin wd[k] = 32'hA0 + DW'(k); ws[k] = 4'hF; end
    do_write(1, 'h38, 3, 2, 2, -1);
    base = got_n;
    do_read(1, 'h30, 3, 2, 1);
    chk("wrap_w30", got_d[base + 0], 32'hA2);
    chk("wrap_w34", got_d[base + 1], 32'hA3);
    chk("wrap_w38", got_d[base + 2], 32'hA0);
    chk("wrap_w3c", got_d[base + 3], 32'hA1);
    do_read(2, 'h38, 3, 2, 2);
    for (int k = 0; k < 3; k++) begin wd[k] = 32'hEEEE_EEEE; ws[k] = 4'hF; end
    do_write(2, 'h30, 2, 2, 2, -1);
    chk("wrap_len2_bresp", got_bresp, 2'b10);
    base = got_n;
    do_read(2, 'h30, 3, 2, 1);
    chk("wrap_len2_keep30", got_d[base + 0], 32'hA2);
    chk("wrap_len2_keep38", got_d[base + 2], 32'hA0);

    // FIXED with single-byte strobes.
    wd[0] = '0; ws[0] = 4'hF;
    do_write(1, 'h40, 0, 2, 1, -1);
    wd[0] = 32'h0000_00AA; ws[0] = 4'h1;
    wd[1] = 32'h0000_BB00; ws[1] = 4'h2;
    wd[2] = 32'h00CC_0000; ws[2] = 4'h4;
    do_write(2, 'h40, 2, 2, 0, -1);
    chk("fixed_bresp", got_bresp, 2'b00);
    base = got_n;
    do_read(2, 'h40, 0, 2, 1);
    chk("fixed_word", got_d[base], 32'h00CC_BBAA);

    // Burst running off the end of the RAM.
    base = got_n;
    do_read(4, MB - 8, 3, 2, 1);
    chk("oor_resp0", got_rr[base + 0], 2'b00);
    chk("oor_resp1", got_rr[base + 1], 2'b00);
    chk("oor_resp2", got_rr[base + 2], 2'b10);
    chk("oor_resp3", got_rr[base + 3], 2'b10);
    chk("oor_data2", got_d[base + 2], 32'h0);
    chk("oor_data3", got_d[base + 3], 32'h0);
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(4, MB - 8, 3, 2, 1, -1);
    chk("oor_bresp", got_bresp, 2'b10);

    // Backpressure on R and B, then early WLAST.
    r_stall = 0;
    rhold = 5;
    do_read(7, 'h80, 3, 2, 1);
    chk("r_held_5", (r_stall >= 5), 1'b1);
    bhold = 5;
    for (int k = 0; k < 2; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(8, 'h90, 1, 2, 1, -1);
    chk("b_held_5", (b_wait_last >= 5), 1'b1);
    chk("b_held_bid", got_bid, 4'd8);
    for (int k = 0; k < 4; k++) begin wd[k] = $urandom; ws[k] = 4'hF; end
    do_write(9, 'hA0, 3, 2, 1, 1);
    chk("early_wlast_bresp", got_bresp, 2'b10);
    do_read(9, 'hA0, 3, 2, 1);

    // Reset in the middle of a long read.
    r_expect(5, 'h100, 7, 2, 1);
    issue_ar(5, 'h100, 7, 2, 1);
    base = got_n;
    t = 0;
    while (got_n < base + 2 && t < 200) begin @(posedge ACLK); t++; end
    tmo("rst_mid_wait", t < 200);
    #1;
    ARESETN = 1'b0;
    #1;
    chk("mid_rst_rvalid", bus.RVALID, 1'b0);
    chk("mid_rst_rlast", bus.RLAST, 1'b0);
    chk("mid_rst_arready", bus.ARREADY, 1'b0);
    chk("mid_rst_awready", bus.AWREADY, 1'b0);
    exp_r.delete();
    rhold = 0;
    repeat (3) @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    chk("post_rst_arready", bus.ARREADY, 1'b1);
    @(posedge ACLK); #1;
    base = got_n;
    do_read(6, 'h10, 3, 2, 1);
    chk("post_rst_rdata0", got_d[base], 32'h1);

    // Randomized mix of bursts.
    for (int i = 0; i < 200; i++) begin
      id = $urandom_range(0, 15);
      a = $urandom_range(0, MB + 64);
      burst = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      size = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 2) : $urandom_range(3, 7);
      if (burst == 2 && $urandom_range(0, 4) != 0) len = (1 << $urandom_range(1, 4)) - 1;
      else len = $urandom_range(0, 15);
      if ($urandom_range(0, 7) == 0) rhold = $urandom_range(1, 4);
      if ($urandom_range(0, 7) == 0) bhold = $urandom_range(1, 4);
      if ($urandom_range(0, 1) == 1) begin
        for (int k = 0; k < 16; k++) begin wd[k] = $urandom; ws[k] = NB'($urandom_range(0, 15)); end
        badlast = ($urandom_range(0, 9) == 0) ? $urandom_range(0, len) : -1;
        do_write(id, a, len, size, burst, badlast);
      end else begin
        do_read(id, a, len, size, burst);
      end
    end

    repeat (4) @(posedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
